// File: rtl/multicycle_control_unit.sv
// Control FSM for the shared multi-cycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Optional feature: define BNE_EN to decode bne (opcode 000101) onto the branch state.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       IorD_o,
    output logic       IR_write_o,
    output logic       PC_en_o,
    output logic [1:0] PC_src_o,
    output logic       ALU_src_A_o,
    output logic [1:0] ALU_src_B_o,
    output logic [2:0] ALU_control_o,
    output logic       reg_dest_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       illegal_op_o,
    output logic       instr_done_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExec,
        StAluWb,
        StAddiEx,
        StAddiWb,
        StBranch,
        StJump
    } state_e;

    state_e     state_q, state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (funct_i)
            FnAdd:   funct_alu = AluAdd;
            FnSub:   funct_alu = AluSub;
            FnAnd:   funct_alu = AluAnd;
            FnOr:    funct_alu = AluOr;
            FnSlt:   funct_alu = AluSlt;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_o     = 1'b0;
        mem_write_o   = 1'b0;
        IorD_o        = 1'b0;
        IR_write_o    = 1'b0;
        PC_en_o       = 1'b0;
        PC_src_o      = 2'b00;
        ALU_src_A_o   = 1'b0;
        ALU_src_B_o   = 2'b00;
        ALU_control_o = 3'b000;
        reg_dest_o    = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        illegal_op_o  = 1'b0;
        instr_done_o  = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;

            StFetch: begin
                mem_req_o     = 1'b1;
                ALU_src_B_o   = 2'b01;
                ALU_control_o = AluAdd;
                if (mem_ready_i) begin
                    IR_write_o = 1'b1;
                    PC_en_o    = 1'b1;
                    state_d    = StDecode;
                end
            end

            StDecode: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ALU_src_B_o   = 2'b11;
                ALU_control_o = AluAdd;
                case (opcode_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype: begin
                        if (funct_ok) begin
                            state_d = StExec;
                        end else begin
                            illegal_op_o = 1'b1;
                            state_d      = StFetch;
                        end
                    end
                    OpAddi: state_d = StAddiEx;
                    OpBeq:  state_d = StBranch;
`ifdef BNE_EN
                    OpBne:  state_d = StBranch;
`endif
                    OpJ:    state_d = StJump;
                    default: begin
                        illegal_op_o = 1'b1;
                        state_d      = StFetch;
                    end
                endcase
            end

            StMemAdr: begin
                ALU_src_A_o   = 1'b1;
                ALU_src_B_o   = 2'b10;
                ALU_control_o = AluAdd;
                state_d       = (opcode_i == OpSw) ? StMemWr : StMemRd;
            end

            StMemRd: begin
                mem_req_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end
            end

            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StMemWr: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                IorD_o      = 1'b1;
                if (mem_ready_i) begin
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end
            end

            StExec: begin
                ALU_src_A_o   = 1'b1;
                ALU_control_o = funct_alu;
                state_d       = StAluWb;
            end

            StAluWb: begin
                reg_write_o  = 1'b1;
                reg_dest_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StAddiEx: begin
                ALU_src_A_o   = 1'b1;
                ALU_src_B_o   = 2'b10;
                ALU_control_o = AluAdd;
                state_d       = StAddiWb;
            end

            StAddiWb: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StBranch: begin
                ALU_src_A_o   = 1'b1;
                ALU_control_o = AluSub;
                PC_src_o      = 2'b01;
`ifdef BNE_EN
                PC_en_o       = (opcode_i == OpBne) ? ~zero_i : zero_i;
`else
                PC_en_o       = zero_i;
`endif
                instr_done_o  = 1'b1;
                state_d       = StFetch;
            end

            StJump: begin
                PC_src_o     = 2'b10;
                PC_en_o      = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            default: state_d = StIdle;
        endcase
    end

endmodule
